ssd_req_arbiter: RTL and testbench

Shares one ssd_sim instance among NUM_REQ independent requesters. Requesters can issue read, write or delete. Arbitration is round-robin and only one command is outstanding at a time. The block drives the ssd_sim single-cycle command strobes, waits for ssd_sim's done, then returns the result to the owning requester. It sits between the host-side command sources and ssd_sim.

---
 rtl/ssd_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ssd_req_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_req_arbiter.sv
// Round-robin arbiter sharing one ssd_sim among NUM_REQ requesters, one command in flight.
// Optional watchdog on the WAIT state is enabled by defining SSD_ARB_TIMEOUT_EN.
module ssd_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int VALUE_SIZE     = 32,
  parameter int DATA_SIZE      = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [2*NUM_REQ-1:0]            req_op,
  input  logic [VALUE_SIZE*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_SIZE*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_SIZE-1:0]            rsp_data,
  output logic [VALUE_SIZE-1:0]           rsp_addr,
  output logic                            rsp_err,
  output logic                            busy,
  output logic                            ssd_write,
  output logic                            ssd_read,
  output logic                            ssd_delete,
  output logic [VALUE_SIZE-1:0]           ssd_addr,
  output logic [DATA_SIZE-1:0]            ssd_data,
  input  logic                            ssd_ready,
  input  logic                            ssd_done,
  input  logic [VALUE_SIZE-1:0]           ssd_addr_out,
  input  logic [DATA_SIZE-1:0]            ssd_data_out
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ssd_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state;
  logic [IW-1:0]           last_grant;
  logic [IW-1:0]           owner;
  logic [IW-1:0]           win;
  logic [IW-1:0]           scan_idx;
  logic                    win_found;
  logic                    done_q;
  logic                    done_rise;
  logic [1:0]              op_arr   [NUM_REQ];
  logic [VALUE_SIZE-1:0]   addr_arr [NUM_REQ];
  logic [DATA_SIZE-1:0]    data_arr [NUM_REQ];

`ifdef SSD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);
  logic [CW-1:0] to_cnt;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i]   = req_op[2*i +: 2];
    assign addr_arr[i] = req_addr[VALUE_SIZE*i +: VALUE_SIZE];
    assign data_arr[i] = req_data[DATA_SIZE*i +: DATA_SIZE];
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scan downward so the final hit is the closest requester after last_grant.
  always_comb begin
    win       = last_grant;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        win       = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  assign done_rise = ssd_done & ~done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      owner      <= '0;
      done_q     <= 1'b0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      ssd_write  <= 1'b0;
      ssd_read   <= 1'b0;
      ssd_delete <= 1'b0;
      ssd_addr   <= '0;
      ssd_data   <= '0;
`ifdef SSD_ARB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      done_q     <= ssd_done;
      req_ack    <= '0;
      rsp_valid  <= '0;
      ssd_write  <= 1'b0;
      ssd_read   <= 1'b0;
      ssd_delete <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found && ssd_ready) begin
            owner   <= win;
            busy    <= 1'b1;
            req_ack <= onehot(win);
            if (op_arr[win] == 2'b11) begin
              // Illegal op never touches the SSD; ssd_addr/ssd_data keep the last issued command.
              rsp_valid <= onehot(win);
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_addr  <= addr_arr[win];
              state     <= RESP;
            end else begin
              ssd_read   <= (op_arr[win] == 2'b00);
              ssd_write  <= (op_arr[win] == 2'b01);
              ssd_delete <= (op_arr[win] == 2'b10);
              ssd_addr   <= addr_arr[win];
              ssd_data   <= data_arr[win];
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
`ifdef SSD_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            rsp_valid <= onehot(owner);
            rsp_err   <= 1'b0;
            rsp_data  <= ssd_data_out;
            rsp_addr  <= ssd_addr_out;
            state     <= RESP;
          end
`ifdef SSD_ARB_TIMEOUT_EN
          // Fires so that RESP lands exactly TIMEOUT_CYCLES after the ISSUE cycle.
          else if (to_cnt == TO_LAST) begin
            rsp_valid <= onehot(owner);
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_addr  <= ssd_addr;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          last_grant <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_req_arbiter.sv
// Directed self-checking bench for ssd_req_arbiter; the bench itself plays the ssd_sim side.
module tb_ssd_req_arbiter;

  localparam int NR = 4;
  localparam int VS = 32;
  localparam int DS = 512;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [2*NR-1:0]   req_op;
  logic [VS*NR-1:0]  req_addr;
  logic [DS*NR-1:0]  req_data;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     rsp_valid;
  logic [DS-1:0]     rsp_data;
  logic [VS-1:0]     rsp_addr;
  logic              rsp_err;
  logic              busy;
  logic              ssd_write;
  logic              ssd_read;
  logic              ssd_delete;
  logic [VS-1:0]     ssd_addr;
  logic [DS-1:0]     ssd_data;
  logic              ssd_ready;
  logic              ssd_done;
  logic [VS-1:0]     ssd_addr_out;
  logic [DS-1:0]     ssd_data_out;

  int passed = 0;
  int total  = 0;

  ssd_req_arbiter #(
    .NUM_REQ(NR), .VALUE_SIZE(VS), .DATA_SIZE(DS), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err), .busy(busy),
    .ssd_write(ssd_write), .ssd_read(ssd_read), .ssd_delete(ssd_delete),
    .ssd_addr(ssd_addr), .ssd_data(ssd_data),
    .ssd_ready(ssd_ready), .ssd_done(ssd_done),
    .ssd_addr_out(ssd_addr_out), .ssd_data_out(ssd_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [VS-1:0] a,
                         input logic [DS-1:0] d);
    req_op[2*r +: 2]    = op;
    req_addr[VS*r +: VS] = a;
    req_data[DS*r +: DS] = d;
    req_valid[r]         = 1'b1;
  endtask

  // Pulse ssd_done for one cycle with the given read-back; returns in the RESP cycle.
  task automatic pulse_done(input logic [DS-1:0] d, input logic [VS-1:0] a);
    ssd_done     = 1'b1;
    ssd_data_out = d;
    ssd_addr_out = a;
    step();
    ssd_done = 1'b0;
  endtask

  // One full legal command from IDLE back to IDLE, with the SSD returning rdat.
  task automatic run_cmd(input int r, input logic [1:0] op, input logic [VS-1:0] a,
                         input logic [DS-1:0] d, input logic [DS-1:0] rdat);
    logic [NR-1:0] oh;
    oh = 4'b0001 << r;
    set_req(r, op, a, d);
    step();
    check("ack", req_ack, oh);
    check("wr_strobe", ssd_write, op == 2'b01);
    check("rd_strobe", ssd_read, op == 2'b00);
    check("del_strobe", ssd_delete, op == 2'b10);
    check("ssd_addr", ssd_addr, a);
    check("ssd_data", ssd_data, d);
    req_valid[r] = 1'b0;
    step();
    check("strobe_1cyc", {ssd_write, ssd_read, ssd_delete}, 3'b000);
    pulse_done(rdat, a);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_err", rsp_err, 1'b0);
    check("rsp_data", rsp_data, rdat);
    check("rsp_addr", rsp_addr, a);
    step();
    check("busy_fall", busy, 1'b0);
    check("rsp_1cyc", rsp_valid, '0);
  endtask

  initial begin
    logic [NR-1:0] oh;
    int            order [5];
    order = '{0, 1, 2, 3, 0};

    reset        = 1'b1;
    req_valid    = '0;
    req_op       = '0;
    req_addr     = '0;
    req_data     = '0;
    ssd_ready    = 1'b1;
    ssd_done     = 1'b0;
    ssd_addr_out = '0;
    ssd_data_out = '0;
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_ack", req_ack, '0);
    check("rst_rsp", rsp_valid, '0);
    check("rst_strobes", {ssd_write, ssd_read, ssd_delete, rsp_err}, 4'b0000);
    check("rst_ssd_addr", ssd_addr, '0);
    reset = 1'b0;

    // Single write from requester 0
    run_cmd(0, 2'b01, 32'h0, {16{32'hA0A0A0A0}}, '0);

    // Round robin with all four requesters holding reads
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int r = 0; r < NR; r++) set_req(r, 2'b00, VS'(r), '0);
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      step();
      check("rr_ack", req_ack, oh);
      check("rr_strobes", {ssd_write, ssd_read, ssd_delete}, 3'b010);
      check("rr_addr", ssd_addr, VS'(order[k]));
      step();
      check("rr_wait", {req_ack, ssd_read}, 5'b0);
      pulse_done(DS'(32'hD000 + k), VS'(order[k]));
      check("rr_rsp", rsp_valid, oh);
      check("rr_data", rsp_data, DS'(32'hD000 + k));
      step();
      check("rr_idle", busy, 1'b0);
    end
    req_valid = '0;

    // Write, read back, delete, read again
    run_cmd(1, 2'b01, 32'h5, {8{64'h1234_5678_9ABC_DEF0}}, '0);
    run_cmd(1, 2'b00, 32'h5, '0, {8{64'h1234_5678_9ABC_DEF0}});
    run_cmd(2, 2'b10, 32'h5, '0, '0);
    run_cmd(1, 2'b00, 32'h5, '0, '0);

    // Illegal op: ack and response together, no strobe
    set_req(3, 2'b11, 32'h77, '0);
    step();
    check("ill_strobes", {ssd_write, ssd_read, ssd_delete}, 3'b000);
    check("ill_ack", req_ack, 4'b1000);
    check("ill_rsp", rsp_valid, 4'b1000);
    check("ill_err", rsp_err, 1'b1);
    check("ill_busy", busy, 1'b1);
    check("ill_ssd_addr_hold", ssd_addr, 32'h5);
    req_valid = '0;
    step();
    check("ill_idle", {busy, rsp_valid, req_ack}, 9'b0);

    // Stale done held high across ISSUE is ignored until it falls and rises again
    ssd_done = 1'b1;
    step();
    set_req(0, 2'b00, 32'h7, '0);
    step();
    check("stale_ack", req_ack, 4'b0001);
    req_valid = '0;
    step();
    step();
    step();
    check("stale_no_rsp", rsp_valid, '0);
    check("stale_busy", busy, 1'b1);
    ssd_done = 1'b0;
    step();
    check("stale_fall_no_rsp", rsp_valid, '0);
    pulse_done(DS'(64'h55), 32'h7);
    check("stale_rsp", rsp_valid, 4'b0001);
    step();

    // ssd_ready low blocks the grant
    ssd_ready = 1'b0;
    set_req(1, 2'b00, 32'h8, '0);
    step();
    step();
    check("notready_ack", req_ack, '0);
    check("notready_busy", {busy, ssd_read}, 2'b00);
    ssd_ready = 1'b1;
    step();
    check("ready_ack", req_ack, 4'b0010);
    check("ready_read", ssd_read, 1'b1);
    req_valid = '0;
    step();
    pulse_done(DS'(64'h99), 32'h8);
    check("ready_rsp", rsp_valid, 4'b0010);
    step();

    // Reset while in WAIT aborts everything immediately
    set_req(2, 2'b01, 32'h9, DS'(64'hBEEF));
    step();
    check("abort_ack", req_ack, 4'b0100);
    step();
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_ssd_addr", ssd_addr, '0);
    check("abort_ssd_data", ssd_data, '0);
    check("abort_rsp_data", rsp_data, '0);
    set_req(0, 2'b00, 32'h1, '0);
    step();
    check("abort_no_rsp", rsp_valid, '0);
    reset = 1'b0;
    step();
    check("post_reset_winner", req_ack, 4'b0001);
    req_valid = '0;
    step();
    pulse_done('0, 32'h1);
    check("post_reset_rsp", rsp_valid, 4'b0001);
    step();

`ifdef SSD_ARB_TIMEOUT_EN
    // Never answer: response must appear exactly 16 cycles after ISSUE
    set_req(1, 2'b00, 32'h33, '0);
    step();
    check("to_ack", req_ack, 4'b0010);
    req_valid = '0;
    for (int i = 1; i < 16; i++) begin
      step();
      check("to_early", rsp_valid, '0);
    end
    step();
    check("to_rsp", rsp_valid, 4'b0010);
    check("to_err", rsp_err, 1'b1);
    check("to_data", rsp_data, '0);
    check("to_addr", rsp_addr, 32'h33);
    step();
    check("to_idle", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
